cpu_seq_ctrl: RTL and testbench

Parametrised instruction-sequencing controller for the simple RISC datapath. It generalises the standalone MOV/ALU controller. It adds:
- an instruction-fetch cycle against the shared memory, with configurable read latency
- PC and IR control
- LDR/STR sequencing
- HALT and illegal-opcode trapping

It sits between the instruction register decoder (opcode/op in) and the datapath/memory controls (register-file, ALU, PC, address and memory-command strobes out). No start input: the block free-runs from reset.

---
 rtl/cpu_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: instruction-sequencing controller for the simple RISC datapath.
// Free-runs from reset through fetch, PC update and decode. It then walks the
// per-instruction state path for MOVI, MOVR, ALU, LDR and STR. HALT and
// illegal opcodes park the machine in HALT until reset is pulled low.
module cpu_seq_ctrl #(
  parameter int RD_LAT   = 1,
  parameter bit HAS_LDST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic [1:0] ALUop,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       addr_sel,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT - 1);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDPC, S_DEC, S_MOVI, S_GETA, S_GETB, S_EXEC,
    S_WRITE, S_ADDR, S_LADR, S_MRD, S_LWR, S_SGETB, S_SPASS, S_MWR, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    I_MOVI, I_MOVR, I_ALU, I_LDR, I_STR, I_HALT
  } instr_e;

  state_e          state_q, state_d;
  instr_e          instr_q, instr_d;
  instr_e          instr_dec;
  logic [CW-1:0]   lat_cnt_q, lat_cnt_d;

  // Classify the IR fields into an instruction kind; anything unknown halts.
  always_comb begin
    instr_dec = I_HALT;
    case (opcode)
      3'b110: begin
        if (op == 2'b10)      instr_dec = I_MOVI;
        else if (op == 2'b00) instr_dec = I_MOVR;
      end
      3'b101:                 instr_dec = I_ALU;
      3'b011: begin
        if (HAS_LDST && op == 2'b00) instr_dec = I_LDR;
      end
      3'b100: begin
        if (HAS_LDST && op == 2'b00) instr_dec = I_STR;
      end
      default:                instr_dec = I_HALT;
    endcase
  end

  // Next-state logic; the instruction kind is latched in DEC and steers the
  // shared GETA/LADR/EXEC states, the latency counter paces the READ phases.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    lat_cnt_d = '0;
    case (state_q)
      S_RST:   state_d = S_IF1;
      S_IF1: begin
        if (lat_cnt_q == LAT_LAST) state_d = S_IF2;
        else                       lat_cnt_d = lat_cnt_q + CW'(1);
      end
      S_IF2:   state_d = S_UPDPC;
      S_UPDPC: state_d = S_DEC;
      S_DEC: begin
        instr_d = instr_dec;
        case (instr_dec)
          I_MOVI:              state_d = S_MOVI;
          I_MOVR:              state_d = S_GETB;
          I_ALU, I_LDR, I_STR: state_d = S_GETA;
          default:             state_d = S_HALT;
        endcase
      end
      S_MOVI:  state_d = S_IF1;
      S_GETA: begin
        case (instr_q)
          I_ALU:        state_d = S_GETB;
          I_LDR, I_STR: state_d = S_ADDR;
          default:      state_d = S_HALT;
        endcase
      end
      S_GETB:  state_d = S_EXEC;
      S_EXEC: begin
        if (instr_q == I_ALU && op == 2'b01) state_d = S_IF1;
        else                                 state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IF1;
      S_ADDR:  state_d = S_LADR;
      S_LADR: begin
        case (instr_q)
          I_LDR:   state_d = S_MRD;
          I_STR:   state_d = S_SGETB;
          default: state_d = S_HALT;
        endcase
      end
      S_MRD: begin
        if (lat_cnt_q == LAT_LAST) state_d = S_LWR;
        else                       lat_cnt_d = lat_cnt_q + CW'(1);
      end
      S_LWR:   state_d = S_IF1;
      S_SGETB: state_d = S_SPASS;
      S_SPASS: state_d = S_MWR;
      S_MWR:   state_d = S_IF1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // State, latched instruction kind and latency counter; reset forces RST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RST;
      instr_q   <= I_HALT;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Moore output decode from the current state (EXEC also forwards op).
  always_comb begin
    nsel      = 3'b001;
    vsel      = 4'b0001;
    asel      = 1'b0;
    bsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    ALUop     = 2'b00;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    addr_sel  = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;
    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDPC: load_pc = 1'b1;
      S_DEC: ;
      S_MOVI: begin
        vsel  = 4'b0100;
        write = 1'b1;
      end
      S_GETA: loada = 1'b1;
      S_GETB: begin
        nsel  = 3'b100;
        loadb = 1'b1;
      end
      S_EXEC: begin
        loadc = 1'b1;
        if (instr_q == I_ALU) begin
          ALUop = op;
          loads = (op == 2'b01);
        end else begin
          asel = 1'b1;
        end
      end
      S_WRITE: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      S_ADDR: begin
        bsel  = 1'b1;
        loadc = 1'b1;
      end
      S_LADR: load_addr = 1'b1;
      S_MRD:  mem_cmd = MEM_READ;
      S_LWR: begin
        mem_cmd = MEM_READ;
        nsel    = 3'b010;
        vsel    = 4'b1000;
        write   = 1'b1;
      end
      S_SGETB: begin
        nsel  = 3'b010;
        loadb = 1'b1;
      end
      S_SPASS: begin
        asel  = 1'b1;
        loadc = 1'b1;
      end
      S_MWR:  mem_cmd = MEM_WRITE;
      S_HALT: halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: scoreboard bench for cpu_seq_ctrl. Three instances cover
// RD_LAT=1, RD_LAT=3 and HAS_LDST=0. The instruction model expands each
// instruction into its per-cycle control pattern. The monitor pops one
// expected pattern per cycle and compares it with the active instance.
module tb_cpu_seq_ctrl;

  typedef struct packed {
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       asel;
    logic       bsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       write;
    logic [1:0] aluop;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } sb_t;

  logic       clk;
  logic       rst_n [3];
  logic [2:0] opc   [3];
  logic [1:0] opv   [3];
  out_t       obs   [3];

  int  active;
  int  n_cmp;
  int  n_bad;
  sb_t sb[$];
  sb_t exp_seq[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam bit HAS = (g != 2);
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       asel, bsel, loada, loadb, loadc, loads, write;
    logic [1:0] aluop;
    logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;

    cpu_seq_ctrl #(.RD_LAT(LAT), .HAS_LDST(HAS)) u_dut (
      .clk      (clk),
      .reset    (rst_n[g]),
      .opcode   (opc[g]),
      .op       (opv[g]),
      .nsel     (nsel),
      .vsel     (vsel),
      .asel     (asel),
      .bsel     (bsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .write    (write),
      .ALUop    (aluop),
      .load_ir  (load_ir),
      .load_pc  (load_pc),
      .reset_pc (reset_pc),
      .load_addr(load_addr),
      .addr_sel (addr_sel),
      .mem_cmd  (mem_cmd),
      .halted   (halted)
    );

    assign obs[g] = {nsel, vsel, asel, bsel, loada, loadb, loadc, loads, write,
                     aluop, load_ir, load_pc, reset_pc, load_addr, addr_sel,
                     mem_cmd, halted};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit has_of(input int k);
    return (k != 2);
  endfunction

  function automatic out_t base();
    out_t o;
    o      = '0;
    o.nsel = 3'b001;
    o.vsel = 4'b0001;
    return o;
  endfunction

  function automatic out_t rst_out();
    out_t o;
    o          = base();
    o.reset_pc = 1'b1;
    o.load_pc  = 1'b1;
    return o;
  endfunction

  function automatic out_t halt_out();
    out_t o;
    o        = base();
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic add(input string tag, input out_t o);
    sb_t e;
    e.v   = o;
    e.tag = tag;
    exp_seq.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s @%0t: got %h required %h", tag, $time, got, exp);
    end
  endtask

  // Monitor: one expected control pattern per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    sb_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, obs[active], e.v);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) sb.push_back(exp_seq[i]);
  endtask

  // Expand one instruction into the control pattern of every cycle it takes.
  task automatic buildInstr(input int lat, input bit has, input logic [2:0] oc,
                            input logic [1:0] o2);
    out_t o;
    exp_seq.delete();
    for (int i = 0; i < lat; i++) begin
      o = base(); o.addr_sel = 1'b1; o.mem_cmd = 2'b01;
      add("fetch_rd", o);
    end
    o = base(); o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1;
    add("fetch_ir", o);
    o = base(); o.load_pc = 1'b1;
    add("pc_update", o);
    add("decode", base());
    if (oc == 3'b110 && o2 == 2'b10) begin
      o = base(); o.vsel = 4'b0100; o.write = 1'b1;
      add("movi_wr", o);
    end else if (oc == 3'b110 && o2 == 2'b00) begin
      o = base(); o.nsel = 3'b100; o.loadb = 1'b1;
      add("movr_rm", o);
      o = base(); o.loadc = 1'b1; o.asel = 1'b1;
      add("movr_pass", o);
      o = base(); o.nsel = 3'b010; o.write = 1'b1;
      add("movr_wr", o);
    end else if (oc == 3'b101) begin
      o = base(); o.loada = 1'b1;
      add("alu_rn", o);
      o = base(); o.nsel = 3'b100; o.loadb = 1'b1;
      add("alu_rm", o);
      o = base(); o.loadc = 1'b1; o.aluop = o2; o.loads = (o2 == 2'b01);
      add("alu_exec", o);
      if (o2 != 2'b01) begin
        o = base(); o.nsel = 3'b010; o.write = 1'b1;
        add("alu_wr", o);
      end
    end else if (has && o2 == 2'b00 && (oc == 3'b011 || oc == 3'b100)) begin
      o = base(); o.loada = 1'b1;
      add("ls_rn", o);
      o = base(); o.bsel = 1'b1; o.loadc = 1'b1;
      add("ls_addr", o);
      o = base(); o.load_addr = 1'b1;
      add("ls_ladr", o);
      if (oc == 3'b011) begin
        for (int i = 0; i < lat; i++) begin
          o = base(); o.mem_cmd = 2'b01;
          add("ldr_rd", o);
        end
        o = base(); o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 4'b1000;
        o.write = 1'b1;
        add("ldr_wr", o);
      end else begin
        o = base(); o.nsel = 3'b010; o.loadb = 1'b1;
        add("str_rd", o);
        o = base(); o.asel = 1'b1; o.loadc = 1'b1;
        add("str_pass", o);
        o = base(); o.mem_cmd = 2'b10;
        add("str_wr", o);
      end
    end else begin
      for (int i = 0; i < 20; i++) add("halt", halt_out());
    end
  endtask

  task automatic applyStimulus(input int k, input logic [2:0] oc, input logic [1:0] o2);
    opc[k] = oc;
    opv[k] = o2;
    buildInstr(lat_of(k), has_of(k), oc, o2);
    flush(exp_seq.size());
    cyc(exp_seq.size());
  endtask

  task automatic doReset(input int k, input int n);
    active   = k;
    rst_n[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{rst_out(), "reset"});
      cyc(1);
    end
    rst_n[k] = 1'b1;
    sb.push_back('{rst_out(), "reset_rel"});
    cyc(1);
  endtask

  task automatic randomInstrs(input int k, input int n);
    int pick;
    for (int i = 0; i < n; i++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0:       applyStimulus(k, 3'b110, 2'b10);
        1:       applyStimulus(k, 3'b110, 2'b00);
        2:       applyStimulus(k, 3'b101, 2'($urandom_range(0, 3)));
        3:       applyStimulus(k, 3'b011, 2'b00);
        default: applyStimulus(k, 3'b100, 2'b00);
      endcase
    end
  endtask

  // Reset pulled low part-way through the data read of an LDR.
  task automatic asyncResetMidMrd(input int k);
    int pre;
    opc[k] = 3'b011;
    opv[k] = 2'b00;
    buildInstr(lat_of(k), 1'b1, 3'b011, 2'b00);
    pre = 2 * lat_of(k) + 5;
    flush(pre);
    cyc(pre);
    #1;
    rst_n[k] = 1'b0;
    sb.push_back('{rst_out(), "async_rst"});
    @(posedge clk);
    #1;
    sb.push_back('{rst_out(), "async_hold"});
    cyc(1);
    rst_n[k] = 1'b1;
    sb.push_back('{rst_out(), "async_rel"});
    cyc(1);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    active = 0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      opc[i]   = 3'b000;
      opv[i]   = 2'b00;
    end
    cyc(1);

    // RD_LAT=1: directed flows, ALU sweep, random mix, then HALT/illegal.
    doReset(0, 3);
    applyStimulus(0, 3'b110, 2'b10);
    for (int o = 0; o < 4; o++) applyStimulus(0, 3'b101, 2'(o));
    applyStimulus(0, 3'b110, 2'b00);
    applyStimulus(0, 3'b011, 2'b00);
    applyStimulus(0, 3'b100, 2'b00);
    randomInstrs(0, 30);
    applyStimulus(0, 3'b111, 2'($urandom_range(0, 3)));
    doReset(0, 2);
    applyStimulus(0, 3'b001, 2'b00);
    doReset(0, 1);
    applyStimulus(0, 3'b110, 2'b10);

    // RD_LAT=3: memory flows, random mix, reset mid data read.
    doReset(1, 2);
    applyStimulus(1, 3'b011, 2'b00);
    applyStimulus(1, 3'b100, 2'b00);
    randomInstrs(1, 30);
    asyncResetMidMrd(1);
    applyStimulus(1, 3'b110, 2'b10);

    // HAS_LDST=0: LDR and STR opcodes trap.
    doReset(2, 2);
    applyStimulus(2, 3'b101, 2'b10);
    applyStimulus(2, 3'b011, 2'b00);
    doReset(2, 1);
    applyStimulus(2, 3'b100, 2'b00);

    cyc(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
